// File: rtl/mem_vec_sequencer.sv
// EX/MEM consumer: unpacks bufferIn, sequences scalar/vector data-memory beats, emits the MEM/WB bundle.
// Optional MEM_SEQ_BOUNDS_EN: beats above MEM_LIMIT are suppressed and raise a sticky memFault.
module mem_vec_sequencer #(
   parameter int N         = 24,
   parameter int M         = 6,
   parameter int AW        = 16,
   parameter int BW        = 2*N*M+18,
   parameter int MEM_LIMIT = 2**AW-1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              inValid,
   input  logic [BW-1:0]     bufferIn,
   output logic              stall,
   output logic [AW-1:0]     memAddr,
   output logic [N-1:0]      memWData,
   output logic              memWE,
   output logic              memRE,
   input  logic [N-1:0]      memRData,
   output logic              wbValid,
   output logic [3:0]        wbRc,
   output logic              wbRegWrite,
   output logic              wbRegWriteV,
   output logic              wbModeSel,
   output logic              wbMemToReg,
   output logic [N*M-1:0]    wbData,
   output logic              memFault
);

   localparam int VW = N*M;
   localparam int LW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [1:0] {IDLE, STORE, LOAD, DRAIN} state_t;

   state_t          state;
   logic [LW-1:0]   lane, lane_nx, last_lane, pend_lane;
   logic            at_last, pend, pend_oob, mode;
   logic [AW-1:0]   base, nx_addr;
   logic [VW-1:0]   sdata, alu, ld_data, ld_merged;
   logic [3:0]      p_rc;
   logic            p_rw, p_rwv, p_m2r;
   logic            acc_ok, nx_ok;

   logic [VW-1:0]   in_sdata, in_alu;
   logic [3:0]      in_rc;
   logic            in_rw, in_m2r, in_mw, in_mode, in_rwv;
   logic            unused_fields;

   assign in_sdata = bufferIn[VW-1:0];
   assign in_rc    = bufferIn[VW +: 4];
   assign in_rw    = bufferIn[VW+4];
   assign in_m2r   = bufferIn[VW+5];
   assign in_mw    = bufferIn[VW+6];
   assign in_alu   = bufferIn[VW+10 +: VW];
   assign in_mode  = bufferIn[2*VW+16];
   assign in_rwv   = bufferIn[2*VW+17];
   // Flags, opCode and opType are consumed upstream.
   assign unused_fields = ^{bufferIn[VW+7 +: 3], bufferIn[2*VW+10 +: 6]};

   assign stall     = (state != IDLE);
   assign lane_nx   = lane + LW'(1);
   assign last_lane = mode ? LW'(M-1) : '0;
   assign at_last   = (lane == last_lane);
   assign nx_addr   = base + AW'(lane_nx);

   // Load beat k lands one edge after its issue cycle; merge it so DRAIN can commit in the same edge.
   always_comb begin
      ld_merged = ld_data;
      if (pend) ld_merged[pend_lane*N +: N] = pend_oob ? '0 : memRData;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         lane        <= '0;
         pend        <= 1'b0;
         pend_lane   <= '0;
         pend_oob    <= 1'b0;
         mode        <= 1'b0;
         base        <= '0;
         sdata       <= '0;
         alu         <= '0;
         ld_data     <= '0;
         p_rc        <= '0;
         p_rw        <= 1'b0;
         p_rwv       <= 1'b0;
         p_m2r       <= 1'b0;
         memAddr     <= '0;
         memWData    <= '0;
         memWE       <= 1'b0;
         memRE       <= 1'b0;
         wbValid     <= 1'b0;
         wbRc        <= '0;
         wbRegWrite  <= 1'b0;
         wbRegWriteV <= 1'b0;
         wbModeSel   <= 1'b0;
         wbMemToReg  <= 1'b0;
         wbData      <= '0;
      end else begin
         wbValid <= 1'b0;
         pend    <= 1'b0;
         if (pend) ld_data <= ld_merged;
         if (flush) begin
            state <= IDLE;
            lane  <= '0;
            memWE <= 1'b0;
            memRE <= 1'b0;
         end else begin
            case (state)
               IDLE: if (inValid) begin
                  base  <= in_alu[AW-1:0];
                  sdata <= in_sdata;
                  alu   <= in_alu;
                  mode  <= in_mode;
                  lane  <= '0;
                  p_rc  <= in_rc;
                  p_rw  <= in_rw;
                  p_rwv <= in_rwv;
                  p_m2r <= in_m2r & ~in_mw;
                  if (in_mw) begin
                     state    <= STORE;
                     memAddr  <= in_alu[AW-1:0];
                     memWData <= in_sdata[N-1:0];
                     memWE    <= acc_ok;
                  end else if (in_m2r) begin
                     state   <= LOAD;
                     memAddr <= in_alu[AW-1:0];
                     memRE   <= acc_ok;
                     ld_data <= '0;
                  end else begin
                     wbValid     <= 1'b1;
                     wbData      <= in_alu;
                     wbRc        <= in_rc;
                     wbRegWrite  <= in_rw;
                     wbRegWriteV <= in_rwv;
                     wbModeSel   <= in_mode;
                     wbMemToReg  <= 1'b0;
                  end
               end
               STORE: begin
                  if (!at_last) begin
                     lane     <= lane_nx;
                     memAddr  <= nx_addr;
                     memWData <= sdata[lane_nx*N +: N];
                     memWE    <= nx_ok;
                  end else begin
                     state       <= IDLE;
                     memWE       <= 1'b0;
                     wbValid     <= 1'b1;
                     wbData      <= alu;
                     wbRc        <= p_rc;
                     wbRegWrite  <= p_rw;
                     wbRegWriteV <= p_rwv;
                     wbModeSel   <= mode;
                     wbMemToReg  <= p_m2r;
                  end
               end
               LOAD: begin
                  pend      <= 1'b1;
                  pend_lane <= lane;
                  pend_oob  <= ~memRE;
                  if (!at_last) begin
                     lane    <= lane_nx;
                     memAddr <= nx_addr;
                     memRE   <= nx_ok;
                  end else begin
                     state <= DRAIN;
                     memRE <= 1'b0;
                  end
               end
               DRAIN: begin
                  state       <= IDLE;
                  wbValid     <= 1'b1;
                  wbData      <= ld_merged;
                  wbRc        <= p_rc;
                  wbRegWrite  <= p_rw;
                  wbRegWriteV <= p_rwv;
                  wbModeSel   <= mode;
                  wbMemToReg  <= p_m2r;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef MEM_SEQ_BOUNDS_EN
   localparam logic [AW:0] LIMIT = (AW+1)'(MEM_LIMIT);

   // Bound check uses the unwrapped sum so a wrapping beat counts as out of range.
   assign acc_ok = ({1'b0, in_alu[AW-1:0]} <= LIMIT);
   assign nx_ok  = (({1'b0, base} + (AW+1)'(lane_nx)) <= LIMIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         memFault <= 1'b0;
      end else if (!flush &&
                   ((state == IDLE && inValid && (in_mw || in_m2r) && !acc_ok) ||
                    ((state == STORE || state == LOAD) && !at_last && !nx_ok))) begin
         memFault <= 1'b1;
      end
   end
`else
   logic [31:0] unused_limit;

   assign acc_ok       = 1'b1;
   assign nx_ok        = 1'b1;
   assign memFault     = 1'b0;
   assign unused_limit = MEM_LIMIT;
`endif

endmodule
